// File: rtl/posit_to_float_es3.sv
// posit<32,3> to IEEE-754 binary32 converter: decode, range, round/pack stages with valid/ready flow control.
// Define POSIT2FLOAT_SUBNORMAL_EN to produce binary32 subnormals; otherwise tiny results flush to signed zero.
module posit_to_float_es3 #(
    parameter int NBITS = 32,
    parameter int ES    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_posit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float,
    output logic             out_inexact,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_nar
);

    // ------------------------------------------------------------------
    // Flow control: each stage loads when it is empty or its content leaves.
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s3_advance;
    logic s2_advance;
    logic s1_advance;
    logic s3_load;
    logic s2_load;

    assign s3_advance = out_valid & out_ready;
    assign s3_load    = ~out_valid | s3_advance;
    assign s2_advance = s2_valid_reg & s3_load;
    assign s2_load    = ~s2_valid_reg | s2_advance;
    assign s1_advance = s1_valid_reg & s2_load;
    assign in_ready   = ~s1_valid_reg | s1_advance;

    // ------------------------------------------------------------------
    // Stage 1 logic: absolute value, regime run, exponent and fraction.
    // ------------------------------------------------------------------
    logic [30:0]       d_abs;
    logic [29:0]       d_inv;
    logic [4:0]        d_run;
    logic [28:0]       d_rem;
    logic [2:0]        d_exp;
    logic [25:0]       d_frac;
    logic signed [8:0] d_k;
    logic signed [8:0] d_scale;
    logic              d_zero;
    logic              d_nar;

    always_comb begin
        d_zero = (in_posit == 32'h0000_0000);
        d_nar  = (in_posit == 32'h8000_0000);
        d_abs  = in_posit[31] ? (~in_posit[30:0] + 31'd1) : in_posit[30:0];
        // A run of ones is counted as a run of zeros on the inverted body.
        d_inv  = d_abs[30] ? ~d_abs[29:0] : d_abs[29:0];
        d_run  = 5'd31;
        for (int i = 0; i < 30; i++) begin
            if (d_inv[i]) begin
                d_run = 5'(30 - i);
            end
        end
        // Drop the run and its terminator; bits past the end read as zero.
        d_rem   = d_abs[28:0] << (d_run - 5'd1);
        d_exp   = d_rem[28:26];
        d_frac  = d_rem[25:0];
        d_k     = d_abs[30] ? ($signed({4'd0, d_run}) - 9'sd1) : -$signed({4'd0, d_run});
        d_scale = (d_k <<< ES) + $signed({6'd0, d_exp});
    end

    logic              s1_sign_reg;
    logic              s1_zero_reg;
    logic              s1_nar_reg;
    logic signed [8:0] s1_scale_reg;
    logic [25:0]       s1_frac_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_nar_reg   <= 1'b0;
            s1_scale_reg <= '0;
            s1_frac_reg  <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg  <= in_posit[31];
                s1_zero_reg  <= d_zero;
                s1_nar_reg   <= d_nar;
                s1_scale_reg <= d_scale;
                s1_frac_reg  <= d_frac;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 logic: biased exponent, overflow, subnormal alignment.
    // ------------------------------------------------------------------
    logic signed [9:0] r_be;
    logic              r_ovf;
    logic [7:0]        r_exp;
    logic [22:0]       r_mant;
    logic              r_g;
    logic              r_s;
    logic              r_tiny;
`ifdef POSIT2FLOAT_SUBNORMAL_EN
    logic [4:0]        r_shamt;
    logic [26:0]       r_sig;
    logic [25:0]       r_sub;
    logic              r_lost;
`endif

    always_comb begin
        r_be   = {s1_scale_reg[8], s1_scale_reg} + 10'sd127;
        r_ovf  = 1'b0;
        r_exp  = 8'd0;
        r_mant = 23'd0;
        r_g    = 1'b0;
        r_s    = 1'b0;
        r_tiny = 1'b0;
`ifdef POSIT2FLOAT_SUBNORMAL_EN
        r_shamt = 5'd0;
        r_sig   = {1'b1, s1_frac_reg};
        r_sub   = 26'd0;
        r_lost  = 1'b0;
`endif
        if (s1_nar_reg || s1_zero_reg) begin
            r_ovf = 1'b0;
        end else if (r_be >= 10'sd255) begin
            r_ovf = 1'b1;
        end else if (r_be <= 10'sd0) begin
            r_tiny = 1'b1;
`ifdef POSIT2FLOAT_SUBNORMAL_EN
            // Beyond 26 places every significand bit is sticky anyway.
            r_shamt = (r_be < -10'sd24) ? 5'd26 : 5'(10'sd1 - r_be);
            r_sub   = 26'(r_sig >> r_shamt);
            r_lost  = |(r_sig & ((27'd1 << r_shamt) - 27'd1));
            r_mant  = r_sub[25:3];
            r_g     = r_sub[2];
            r_s     = (|r_sub[1:0]) | r_lost;
`else
            r_s     = 1'b1;
`endif
        end else begin
            r_exp  = r_be[7:0];
            r_mant = s1_frac_reg[25:3];
            r_g    = s1_frac_reg[2];
            r_s    = |s1_frac_reg[1:0];
        end
    end

    logic        s2_sign_reg;
    logic        s2_nar_reg;
    logic        s2_ovf_reg;
    logic [7:0]  s2_exp_reg;
    logic [22:0] s2_mant_reg;
    logic        s2_g_reg;
    logic        s2_s_reg;
    logic        s2_tiny_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_nar_reg   <= 1'b0;
            s2_ovf_reg   <= 1'b0;
            s2_exp_reg   <= '0;
            s2_mant_reg  <= '0;
            s2_g_reg     <= 1'b0;
            s2_s_reg     <= 1'b0;
            s2_tiny_reg  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_sign_reg <= s1_sign_reg;
                s2_nar_reg  <= s1_nar_reg;
                s2_ovf_reg  <= r_ovf;
                s2_exp_reg  <= r_exp;
                s2_mant_reg <= r_mant;
                s2_g_reg    <= r_g;
                s2_s_reg    <= r_s;
                s2_tiny_reg <= r_tiny;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 logic: round to nearest even and pack.
    // ------------------------------------------------------------------
    logic        p_up;
    logic [30:0] p_sum;
    logic [31:0] p_float;
    logic        p_inexact;
    logic        p_ovf;
    logic        p_unf;
    logic        p_nar;

    always_comb begin
        p_up = s2_g_reg & (s2_s_reg | s2_mant_reg[0]);
        // Mantissa carry ripples into the exponent; a subnormal becomes the smallest normal.
        p_sum     = {s2_exp_reg, s2_mant_reg} + {30'd0, p_up};
        p_float   = {s2_sign_reg, p_sum};
        p_inexact = s2_g_reg | s2_s_reg;
        p_ovf     = 1'b0;
        p_unf     = (s2_g_reg | s2_s_reg) & s2_tiny_reg;
        p_nar     = 1'b0;
        if (s2_nar_reg) begin
            p_float   = 32'h7FC0_0000;
            p_inexact = 1'b0;
            p_unf     = 1'b0;
            p_nar     = 1'b1;
        end else if (s2_ovf_reg || (p_sum[30:23] == 8'hFF)) begin
            p_float   = {s2_sign_reg, 31'h7F80_0000};
            p_inexact = 1'b1;
            p_ovf     = 1'b1;
            p_unf     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_float     <= '0;
            out_inexact   <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_nar       <= 1'b0;
        end else if (s3_load) begin
            out_valid <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_float     <= p_float;
                out_inexact   <= p_inexact;
                out_overflow  <= p_ovf;
                out_underflow <= p_unf;
                out_nar       <= p_nar;
            end
        end
    end

endmodule

// File: tb/tb_posit_to_float_es3.sv
// Self-checking bench for posit_to_float_es3: directed values, backpressure, random stream, reset mid-stream.
module tb_posit_to_float_es3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_posit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_nar;

    always #5 clk = ~clk;

    posit_to_float_es3 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_posit     (in_posit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_float    (out_float),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_nar      (out_nar)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          lat_on  = 1'b0;
    logic [35:0] exp_q[$];
    int          stamp_q[$];
    logic [31:0] dir_in[12];
    logic [35:0] dir_exp[12];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: posit value as a real number, then RNE onto the binary32 grid.
    // Result layout: {float, inexact, overflow, underflow, nar}.
    function automatic logic [35:0] model(input logic [31:0] p);
        logic [31:0] a;
        bit          sgn;
        int          run, pos, k, e, scale, qe, field, ni;
        real         frac, w, v, n, rem;
        bit          inex;
        if (p == 32'h0) return 36'h0;
        if (p == 32'h8000_0000) return {32'h7FC0_0000, 4'b0001};
        sgn = p[31];
        a   = sgn ? -p : p;
        run = 0;
        pos = 30;
        while (pos >= 0 && a[pos] == a[30]) begin
            run++;
            pos--;
        end
        pos--;
        k = a[30] ? run - 1 : -run;
        e = 0;
        for (int i = 0; i < 3; i++) begin
            e = e * 2;
            if (pos >= 0) begin
                e = e + int'(a[pos]);
                pos--;
            end
        end
        frac = 0.0;
        w    = 0.5;
        while (pos >= 0) begin
            if (a[pos]) frac = frac + w;
            w = w / 2.0;
            pos--;
        end
        scale = 8 * k + e;
        v     = (1.0 + frac) * (2.0 ** scale);
        if (scale >= 128) return {sgn, 31'h7F80_0000, 4'b1100};
`ifndef POSIT2FLOAT_SUBNORMAL_EN
        if (scale <= -127) return {sgn, 31'h0, 4'b1010};
`endif
        qe   = (scale - 23 > -149) ? scale - 23 : -149;
        n    = v / (2.0 ** qe);
        ni   = $rtoi(n);
        rem  = n - ni;
        inex = (rem != 0.0);
        if (rem > 0.5 || (rem == 0.5 && (ni % 2) == 1)) ni++;
        if (ni >= (1 << 24)) begin
            ni = ni / 2;
            qe++;
        end
        if (ni < (1 << 23)) return {sgn, 31'(ni), inex, 1'b0, inex && (scale <= -127), 1'b0};
        field = qe + 23 + 127;
        if (field >= 255) return {sgn, 31'h7F80_0000, 4'b1100};
        return {sgn, 8'(field), 23'(ni - (1 << 23)), inex, 1'b0, inex && (scale <= -127), 1'b0};
    endfunction

    function automatic logic ordy_of(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_posit();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       r = r;
            1:       r = r >> $urandom_range(0, 31);
            2:       r = r >> $urandom_range(15, 20);
            default: r = 32'h7FFF_FFFF ^ (r >> $urandom_range(1, 31));
        endcase
        if ($urandom_range(0, 1) == 1) r = -r;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check just after, predict what the next edge transfers.
    task automatic step(input logic iv, input logic [31:0] ip, input logic ordy,
                        input logic [35:0] expv, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        in_posit  = ip;
        out_ready = ordy;
        #1;
        check("in_ready", {63'd0, in_ready}, (exp_q.size() == 3 && !ordy) ? 64'd0 : 64'd1);
        if (exp_q.size() == 0) begin
            check("no_valid_when_empty", {63'd0, out_valid}, 64'd0);
        end else if (out_valid) begin
            check("result", {28'd0, out_float, out_inexact, out_overflow, out_underflow, out_nar},
                  {28'd0, exp_q[0]});
            if (ordy) begin
                $display("[TB] cyc %0d out %08h ix=%b ov=%b uf=%b nar=%b", cyc, out_float,
                         out_inexact, out_overflow, out_underflow, out_nar);
                if (lat_on) check("latency", 64'(cyc - stamp_q[0]), 64'd3);
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            exp_q.push_back(expv);
            stamp_q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic send(input logic [31:0] p, input logic [35:0] e, input int mode);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            step(1'b1, p, ordy_of(mode), e, acc);
            tries++;
        end while (!acc && tries < 100);
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int mode);
        logic acc;
        step(1'b0, 32'h0, ordy_of(mode), 36'h0, acc);
    endtask

    task automatic drain(input int mode);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            idle(mode);
            budget++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_in[0]  = 32'h4000_0000; dir_exp[0]  = {32'h3F80_0000, 4'b0000};
        dir_in[1]  = 32'hC000_0000; dir_exp[1]  = {32'hBF80_0000, 4'b0000};
        dir_in[2]  = 32'h4400_0000; dir_exp[2]  = {32'h4000_0000, 4'b0000};
        dir_in[3]  = 32'h4000_0004; dir_exp[3]  = {32'h3F80_0000, 4'b1000};
        dir_in[4]  = 32'h4000_000C; dir_exp[4]  = {32'h3F80_0002, 4'b1000};
        dir_in[5]  = 32'h8000_0000; dir_exp[5]  = {32'h7FC0_0000, 4'b0001};
        dir_in[6]  = 32'h7FFF_FFFF; dir_exp[6]  = {32'h7F80_0000, 4'b1100};
        dir_in[7]  = 32'h0000_0000; dir_exp[7]  = {32'h0000_0000, 4'b0000};
`ifdef POSIT2FLOAT_SUBNORMAL_EN
        dir_in[8]  = 32'h0000_3800; dir_exp[8]  = {32'h0008_0000, 4'b0000};
`else
        dir_in[8]  = 32'h0000_3800; dir_exp[8]  = {32'h0000_0000, 4'b1010};
`endif
        dir_in[9]  = 32'h0000_0001; dir_exp[9]  = {32'h0000_0000, 4'b1010};
        dir_in[10] = 32'h8000_0001; dir_exp[10] = {32'hFF80_0000, 4'b1100};
        dir_in[11] = 32'hFFFF_FFFF; dir_exp[11] = {32'h8000_0000, 4'b1010};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_posit  = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_data", {28'd0, out_float, out_inexact, out_overflow, out_underflow, out_nar}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed values, out_ready held high, latency checked.
        lat_on = 1'b1;
        for (int i = 0; i < 12; i++) send(dir_in[i], dir_exp[i], 0);
        drain(0);
        lat_on = 1'b0;

        // Backpressure with out_ready pattern 1,0,0,1.
        for (int i = 0; i < 8; i++) send(dir_in[i], dir_exp[i], 1);
        drain(1);

        // Randomized stream against the reference model.
        for (int t = 0; t < 400; t++) begin
            logic [31:0] p;
            p = rand_posit();
            send(p, model(p), 2);
            if ($urandom_range(0, 3) == 0) idle(2);
        end
        drain(2);

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) send(dir_in[i + 2], dir_exp[i + 2], 3);
        check("inflight_count", 64'(exp_q.size()), 64'd3);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_out_data", {28'd0, out_float, out_inexact, out_overflow, out_underflow, out_nar}, 64'd0);
        exp_q.delete();
        stamp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postreset_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 5; i++) idle(0);
        lat_on = 1'b1;
        send(dir_in[4], dir_exp[4], 0);
        drain(0);
        lat_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
